// File: rtl/tmds_tm_choice_if.sv
// Pixel-side bus for the TMDS transition-minimisation stage: input byte plus
// the registered 9-bit qm word and its ones count.
interface tmds_tm_choice_if;
  logic       valid_in;
  logic [7:0] data_in;
  logic [8:0] qm_out;
  logic [3:0] qm_ones_out;
  logic       valid_out;

  modport master (
    output valid_in,
    output data_in,
    input  qm_out,
    input  qm_ones_out,
    input  valid_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output qm_out,
    output qm_ones_out,
    output valid_out
  );
endinterface

// File: rtl/tmds_tm_choice.sv
// TMDS stage 1: XOR/XNOR chaining of one colour byte to minimise transitions,
// registered with one cycle of latency and a ones count for DC balancing.
module tmds_tm_choice (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  tmds_tm_choice_if.slave        bus
);

  logic [3:0] w_dataOnes;
  logic       w_useXnor;
  logic [8:0] w_qm;
  logic [3:0] w_qmOnes;

  logic [8:0] r_qm;
  logic [3:0] r_qmOnes;
  logic       r_valid;

  always_comb begin
    w_dataOnes = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_dataOnes = w_dataOnes + {3'd0, bus.data_in[i]};
    end
  end

  // Ties at four ones are broken on bit 0 so the choice is deterministic.
  assign w_useXnor = (w_dataOnes > 4'd4) ||
                     ((w_dataOnes == 4'd4) && !bus.data_in[0]);

  always_comb begin
    w_qm    = 9'h000;
    w_qm[0] = bus.data_in[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_useXnor ? ~(w_qm[i-1] ^ bus.data_in[i])
                          :  (w_qm[i-1] ^ bus.data_in[i]);
    end
    w_qm[8] = ~w_useXnor;
  end

  always_comb begin
    w_qmOnes = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_qmOnes = w_qmOnes + {3'd0, w_qm[i]};
    end
  end

  // Data registers only load on valid so idle cycles hold the last word.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_qm     <= 9'h000;
      r_qmOnes <= 4'd0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.valid_in;
      if (bus.valid_in) begin
        r_qm     <= w_qm;
        r_qmOnes <= w_qmOnes;
      end
    end
  end

  assign bus.qm_out      = r_qm;
  assign bus.qm_ones_out = r_qmOnes;
  assign bus.valid_out   = r_valid;

endmodule

// File: tb/tb_tmds_tm_choice.sv
// Self-checking bench for tmds_tm_choice: directed cases, reset behaviour,
// exhaustive byte sweep and random valid/data traffic against a closed-form model.
module tb_tmds_tm_choice;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic [8:0] expQm;
  logic [3:0] expOnes;
  logic       expValid;

  tmds_tm_choice_if bus ();

  tmds_tm_choice dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit i of an XOR chain is the parity of data[i:0]; XNOR adds one
  // inversion per link, so odd positions come out inverted.
  function automatic logic [8:0] modelQm(input logic [7:0] d);
    logic [8:0] q;
    logic [7:0] mask;
    int         ones;
    bit         useXnor;
    ones    = $countones(d);
    useXnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q       = '0;
    for (int i = 0; i < 8; i++) begin
      mask = 8'((16'd1 << (i + 1)) - 16'd1);
      q[i] = (^(d & mask)) ^ (useXnor && (i % 2 == 1));
    end
    q[8] = !useXnor;
    return q;
  endfunction

  task automatic checkValue(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".qm"},    bus.qm_out, expQm);
    checkValue({tag, ".ones"},  {5'd0, bus.qm_ones_out}, {5'd0, expOnes});
    checkValue({tag, ".valid"}, {8'd0, bus.valid_out}, {8'd0, expValid});
  endtask

  // Drives one cycle and advances the expected output registers.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    logic [8:0] q;
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    expValid = v;
    if (v) begin
      q       = modelQm(d);
      expQm   = q;
      expOnes = 4'($countones(q[7:0]));
    end
  endtask

  initial begin
    logic [7:0] stream [6];
    logic [8:0] streamExp [6];
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    expQm        = 9'h000;
    expOnes      = 4'd0;
    expValid     = 1'b0;

    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h00);
    checkOutput("zero");
    checkValue("zero.const", bus.qm_out, 9'b1_0000_0000);

    stream    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    streamExp = '{9'b1_1111_1111, 9'b1_1111_1110, 9'b1_0000_0001,
                  9'b1_1111_1100, 9'b1_0000_0011, 9'b1_0000_0010};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, stream[i]);
      checkOutput("stream");
      checkValue("stream.const", bus.qm_out, streamExp[i]);
    end

    applyStimulus(1'b1, 8'hFF);
    checkOutput("ff");
    checkValue("ff.const", bus.qm_out, 9'b0_1111_1111);
    checkValue("ff.ones", {5'd0, bus.qm_ones_out}, 9'd8);

    applyStimulus(1'b1, 8'h0F);
    checkOutput("tie0f");
    checkValue("tie0f.const", bus.qm_out, 9'b1_0000_0101);
    applyStimulus(1'b1, 8'hF0);
    checkOutput("tief0");
    checkValue("tief0.const", bus.qm_out, 9'b0_1111_1010);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'($urandom));
      checkOutput("idle");
      checkValue("idle.hold", bus.qm_out, 9'b0_1111_1010);
    end

    applyStimulus(1'b1, 8'h37);
    applyStimulus(1'b1, 8'hA5);
    checkOutput("preReset");
    rst_n = 1'b0;
    #2;
    expQm    = 9'h000;
    expOnes  = 4'd0;
    expValid = 1'b0;
    checkOutput("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'h01);
    checkOutput("postReset");
    checkValue("postReset.const", bus.qm_out, 9'b1_1111_1111);

    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i));
      checkOutput("sweep");
    end

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom));
      checkOutput("random");
    end

    applyStimulus(1'b0, 8'h00);
    checkOutput("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
